// File: rtl/rr_arbiter_8_pkg.sv
// Shared constants, FSM state type and request-rotation helper for the
// 8-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {IDLE, GRANT} arb_state_e;

  // Rotate right so that bit 0 of the result is req[ptr].
  function automatic logic [N_REQ-1:0] rotate_req(input logic [N_REQ-1:0] req,
                                                  input logic [IDX_W-1:0] ptr);
    return N_REQ'({req, req} >> ptr);
  endfunction

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter_8_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  modport master (output req, done, input gnt, gnt_idx, gnt_valid, timeout);
  modport slave  (input req, done, output gnt, gnt_idx, gnt_valid, timeout);

endinterface

// File: rtl/rr_arbiter_8_prio_enc.sv
// Fixed-priority encoder: reports the index of the lowest set input bit.
module prio_enc_8_3
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] in_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Scanning downwards lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx_o = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (in_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign valid_o = |in_i;

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with registered grants and a dead cycle between
// grants. Define ARB_TIMEOUT_EN to force-release grants held HOLD_MAX cycles.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input logic           clk,
  input logic           rst,
  rr_arbiter_8_if.slave bus
);

  if (HOLD_MAX < 1) begin : gHoldCheck
    $error("rr_arbiter_8: HOLD_MAX must be at least 1");
  end

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;

  logic [N_REQ-1:0] rotReq;
  logic [IDX_W-1:0] encIdx;
  logic             encValid;
  logic [IDX_W-1:0] selIdx;
  logic             relNormal;
  logic             releaseGrant;

  // Rotating by ptr makes the encoder's "lowest bit wins" start the search at ptr.
  assign rotReq = rotate_req(bus.req, ptr_q);

  prio_enc_8_3 u_prio_enc (
    .in_i    (rotReq),
    .idx_o   (encIdx),
    .valid_o (encValid)
  );

  assign selIdx    = ptr_q + encIdx;
  assign relNormal = bus.done || !bus.req[idx_q];

`ifdef ARB_TIMEOUT_EN
  localparam int                CNT_W     = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] holdCnt_q, holdCnt_d;
  logic             timeout_q, timeout_d;
  logic             expire;

  // holdCnt_q counts completed GRANT cycles, so the edge ending cycle HOLD_MAX expires.
  assign expire = (holdCnt_q == HOLD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holdCnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      holdCnt_q <= holdCnt_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    idx_d        = idx_q;
    valid_d      = valid_q;
    releaseGrant = 1'b0;
`ifdef ARB_TIMEOUT_EN
    holdCnt_d    = holdCnt_q;
    timeout_d    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (encValid) begin
          state_d = GRANT;
          gnt_d   = N_REQ'(1) << selIdx;
          idx_d   = selIdx;
          valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          holdCnt_d = '0;
`endif
        end
      end
      GRANT: begin
        // A normal release wins over expiry on the same edge, suppressing timeout.
        if (relNormal) begin
          releaseGrant = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (expire) begin
          releaseGrant = 1'b1;
          timeout_d    = 1'b1;
        end else begin
          holdCnt_d = holdCnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (releaseGrant) begin
      state_d = IDLE;
      ptr_d   = idx_q + IDX_W'(1);
      gnt_d   = '0;
      idx_d   = '0;
      valid_d = 1'b0;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout   = timeout_q;
`else
  assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: a request-list model checked every
// cycle plus directed vectors with literal expectations.
module tb_rr_arbiter_8;

  localparam int HOLD = 4;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  rr_arbiter_8_if bus ();

  rr_arbiter_8 #(.HOLD_MAX(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: the holder is an integer index (-1 when idle), ptr an integer.
  int mHolder  = -1;
  int mPtr     = 0;
  int mHeld    = 0;
  bit mTimeout = 1'b0;

  always @(posedge clk or posedge rst) begin
    bit found;
    if (rst) begin
      mHolder  = -1;
      mPtr     = 0;
      mHeld    = 0;
      mTimeout = 1'b0;
    end else begin
      mTimeout = 1'b0;
      if (mHolder < 0) begin
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
          if (!found && bus.req[(mPtr + k) % 8]) begin
            found   = 1'b1;
            mHolder = (mPtr + k) % 8;
            mHeld   = 1;
          end
        end
      end else if (bus.done || !bus.req[mHolder]) begin
        mPtr    = (mHolder + 1) % 8;
        mHolder = -1;
      end
`ifdef ARB_TIMEOUT_EN
      else if (mHeld >= HOLD) begin
        mPtr     = (mHolder + 1) % 8;
        mHolder  = -1;
        mTimeout = 1'b1;
      end
`endif
      else begin
        mHeld++;
      end
    end
  end

  function automatic void compareOne(input string name, input logic [7:0] act,
                                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Every cycle, one sample after the edge, the DUT must agree with the model.
  always @(posedge clk) begin
    logic [7:0] eGnt;
    #1;
    eGnt = (mHolder < 0) ? 8'h00 : (8'h01 << mHolder);
    compareOne("model_gnt",       bus.gnt,                 eGnt);
    compareOne("model_gnt_idx",   {5'b0, bus.gnt_idx},     (mHolder < 0) ? 8'h00 : 8'(mHolder));
    compareOne("model_gnt_valid", {7'b0, bus.gnt_valid},   {7'b0, (mHolder >= 0)});
    compareOne("model_timeout",   {7'b0, bus.timeout},     {7'b0, mTimeout});
  end

  task automatic applyStimulus(input logic [7:0] r, input logic d);
    @(negedge clk);
    bus.req  = r;
    bus.done = d;
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] eGnt,
                             input logic [2:0] eIdx, input logic eValid, input logic eTo);
    compareOne({name, "_gnt"},   bus.gnt,               eGnt);
    compareOne({name, "_idx"},   {5'b0, bus.gnt_idx},   {5'b0, eIdx});
    compareOne({name, "_valid"}, {7'b0, bus.gnt_valid}, {7'b0, eValid});
    compareOne({name, "_to"},    {7'b0, bus.timeout},   {7'b0, eTo});
  endtask

  initial begin
    rst      = 1'b1;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] idle after reset");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'h00, 1'b0);
      checkOutput("idle", 8'h00, 3'd0, 1'b0, 1'b0);
    end

    $display("[TB] basic round-robin from ptr 0");
    applyStimulus(8'b0001_0100, 1'b0);
    checkOutput("first_grant", 8'h04, 3'd2, 1'b1, 1'b0);
    applyStimulus(8'b0001_0100, 1'b1);
    checkOutput("release_2", 8'h00, 3'd0, 1'b0, 1'b0);
    applyStimulus(8'b0001_0100, 1'b0);
    checkOutput("next_grant", 8'h10, 3'd4, 1'b1, 1'b0);
    applyStimulus(8'b0001_0100, 1'b1);
    checkOutput("release_4", 8'h00, 3'd0, 1'b0, 1'b0);

    $display("[TB] wrap 7 -> 0");
    applyStimulus(8'h80, 1'b0);
    checkOutput("grant_7", 8'h80, 3'd7, 1'b1, 1'b0);
    applyStimulus(8'h81, 1'b1);
    checkOutput("release_7", 8'h00, 3'd0, 1'b0, 1'b0);
    applyStimulus(8'h81, 1'b0);
    checkOutput("wrap_grant_0", 8'h01, 3'd0, 1'b1, 1'b0);

    $display("[TB] all requesting after reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      applyStimulus(8'hFF, 1'b0);
      checkOutput("ff_grant", 8'h01 << (i % 8), 3'(i % 8), 1'b1, 1'b0);
      applyStimulus(8'hFF, 1'b1);
      checkOutput("ff_gap", 8'h00, 3'd0, 1'b0, 1'b0);
    end

    $display("[TB] hold, drop and reassert");
    applyStimulus(8'h09, 1'b0);
    checkOutput("grant_3", 8'h08, 3'd3, 1'b1, 1'b0);
    applyStimulus(8'hFF, 1'b0);
    checkOutput("hold_3", 8'h08, 3'd3, 1'b1, 1'b0);
    applyStimulus(8'hF7, 1'b0);
    checkOutput("drop_3", 8'h00, 3'd0, 1'b0, 1'b0);
    applyStimulus(8'h09, 1'b0);
    checkOutput("reassert_skips_3", 8'h01, 3'd0, 1'b1, 1'b0);
    applyStimulus(8'h09, 1'b1);
    checkOutput("release_0", 8'h00, 3'd0, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1);
    checkOutput("done_in_idle", 8'h00, 3'd0, 1'b0, 1'b0);

    $display("[TB] reset mid-grant");
    applyStimulus(8'h20, 1'b0);
    checkOutput("grant_5", 8'h20, 3'd5, 1'b1, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst      = 1'b0;
    bus.req  = 8'h80;
    bus.done = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("post_reset_7", 8'h80, 3'd7, 1'b1, 1'b0);
    applyStimulus(8'h80, 1'b1);
    checkOutput("release_7b", 8'h00, 3'd0, 1'b0, 1'b0);

    $display("[TB] long hold with a single requester");
    applyStimulus(8'h02, 1'b0);
    checkOutput("hold_start", 8'h02, 3'd1, 1'b1, 1'b0);
    for (int i = 0; i < HOLD - 1; i++) begin
      applyStimulus(8'h02, 1'b0);
      checkOutput("hold_cycle", 8'h02, 3'd1, 1'b1, 1'b0);
    end
    applyStimulus(8'h02, 1'b0);
`ifdef ARB_TIMEOUT_EN
    checkOutput("forced_release", 8'h00, 3'd0, 1'b0, 1'b1);
    applyStimulus(8'h02, 1'b0);
    checkOutput("regrant_1", 8'h02, 3'd1, 1'b1, 1'b0);
`else
    checkOutput("no_timeout", 8'h02, 3'd1, 1'b1, 1'b0);
    applyStimulus(8'h02, 1'b0);
    checkOutput("still_held", 8'h02, 3'd1, 1'b1, 1'b0);
`endif
    applyStimulus(8'h02, 1'b1);
    checkOutput("final_release", 8'h00, 3'd0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
